// File: rtl/cmp_tracker.sv
// Registered a/b comparator with running max/min of accepted a values and a
// saturating count of equal pairs; a two-state FSM marks when tracking is live.
module cmp_tracker #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 clear,
    input  logic                 signed_mode,
    input  logic                 data_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 gt,
    output logic                 lt,
    output logic                 eq,
    output logic                 result_valid,
    output logic [WIDTH-1:0]     max_val,
    output logic [WIDTH-1:0]     min_val,
    output logic [CNT_WIDTH-1:0] eq_count,
    output logic                 eq_sat,
    output logic                 tracking
);

    typedef enum logic {IDLE, TRACK} state_t;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = {CNT_WIDTH{1'b1}};

    state_t state, state_nx;
    logic   accept;
    logic   trk_signed;

    function automatic logic above(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic s);
        above = s ? ($signed(x) > $signed(y)) : (x > y);
    endfunction

    assign accept   = data_valid & ~clear;
    assign tracking = (state == TRACK);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clear)           state_nx = IDLE;
        else if (data_valid) state_nx = TRACK;
    end

    // Compare flags use the live mode; they hold across clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            gt           <= 1'b0;
            lt           <= 1'b0;
            eq           <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= accept;
            if (accept) begin
                gt <= above(a, b, signed_mode);
                lt <= above(b, a, signed_mode);
                eq <= (a == b);
            end
        end
    end

    // Max/min compare in the mode captured by the first sample after IDLE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            max_val    <= '0;
            min_val    <= '0;
            trk_signed <= 1'b0;
        end else if (clear) begin
            max_val    <= '0;
            min_val    <= '0;
            trk_signed <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                max_val    <= a;
                min_val    <= a;
                trk_signed <= signed_mode;
            end else begin
                if (above(a, max_val, trk_signed)) max_val <= a;
                if (above(min_val, a, trk_signed)) min_val <= a;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            eq_count <= '0;
            eq_sat   <= 1'b0;
        end else if (clear) begin
            eq_count <= '0;
            eq_sat   <= 1'b0;
        end else if (accept && (a == b) && (eq_count != MAX_CNT)) begin
            eq_count <= eq_count + 1'b1;
            if (eq_count == MAX_CNT - 1'b1) eq_sat <= 1'b1;
        end
    end

endmodule

// File: doc/cmp_tracker.md
CMP_TRACKER -- requirements
Module: cmp_tracker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 8, giving the equal-count width in bits (legal range 2..32).
REQ-003 The block SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 The block SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port clear  input  1  synchronous restart of tracking state.
REQ-006 The block SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned compare.
REQ-007 The block SHALL have port data_valid  input  1  the a/b pair is presented this cycle.
REQ-008 The block SHALL have port a  input  WIDTH  first operand.
REQ-009 The block SHALL have port b  input  WIDTH  second operand.
REQ-010 The block SHALL have port gt  output  1  registered a>b.
REQ-011 The block SHALL have port lt  output  1  registered a<b.
REQ-012 The block SHALL have port eq  output  1  registered a==b.
REQ-013 The block SHALL have port result_valid  output  1  one-cycle pulse when gt/lt/eq are updated.
REQ-014 The block SHALL have port max_val  output  WIDTH  running maximum of accepted a values.
REQ-015 The block SHALL have port min_val  output  WIDTH  running minimum of accepted a values.
REQ-016 The block SHALL have port eq_count  output  CNT_WIDTH  number of accepted pairs with a==b.
REQ-017 The block SHALL have port eq_sat  output  1  sticky flag; eq_count has saturated.
REQ-018 The block SHALL have port tracking  output  1  high when the FSM is in TRACK.

Function
REQ-019 Accept: a pair SHALL be accepted on a rising clk edge with data_valid=1 and clear=0.
REQ-020 Accepted pair: gt/lt/eq SHALL update on that edge (1-cycle latency), exactly one of them high, result_valid=1 for that cycle only.
REQ-021 No accept: gt/lt/eq SHALL hold their last values and result_valid SHALL be 0.
REQ-022 FSM SHALL have two states: IDLE (no sample since reset/clear) and TRACK.
REQ-023 IDLE + accept -> TRACK; max_val=min_val=a; the current signed_mode value SHALL be latched as the tracked mode.
REQ-024 In TRACK, each accept SHALL update max_val if a>max_val and min_val if a<min_val, comparing in the latched mode; the FSM stays in TRACK.
REQ-025 gt/lt/eq SHALL use the live signed_mode of the accepting cycle; only max/min tracking uses the latched mode, held until clear or reset.
REQ-026 Every accept with a==b SHALL increment eq_count; at 2^CNT_WIDTH-1 it SHALL hold (no wrap) and eq_sat SHALL set; eq_sat stays set until clear or reset.
REQ-027 clear=1 SHALL force IDLE, max_val=min_val=0, eq_count=0, eq_sat=0, result_valid=0; gt/lt/eq hold their values.
REQ-028 clear and data_valid high together: clear SHALL win and the pair SHALL be discarded.
REQ-029 Signed compare SHALL treat the MSB as sign across the full WIDTH; no width extension is visible at the outputs.

Reset
REQ-030 n_rst=0 SHALL immediately, without waiting for clk, force gt=0, lt=0, eq=0, result_valid=0, max_val=0, min_val=0, eq_count=0, eq_sat=0, FSM=IDLE (tracking=0).
REQ-031 Reset asserted mid-stream SHALL discard all state; the first accept after n_rst is released SHALL behave as the first sample after IDLE.

Verification (WIDTH=16, CNT_WIDTH=8)
REQ-032 Unsigned: signed_mode=0, a=0x8000, b=0x0001, one valid cycle -> next cycle gt=1, lt=0, eq=0, result_valid=1, then result_valid=0 with gt held at 1.
REQ-033 Signed: signed_mode=1, a=0x8000, b=0x0001 -> lt=1; a=0xFFFF, b=0xFFFF -> eq=1, eq_count=1.
REQ-034 Tracking: signed_mode=1, a=5, 0xFFFD, 9 on consecutive valid cycles (b=0) -> max_val=9, min_val=0xFFFD, tracking=1.
REQ-035 Saturation: 300 accepted pairs with a==b=0x1234 -> eq_count=255 and eq_sat=1 from the 255th accept onward.
REQ-036 Clear collision: in TRACK, clear=1 with data_valid=1, a=7, b=3 -> tracking=0, max_val=0, min_val=0, eq_count=0, result_valid=0, gt/lt/eq unchanged.
REQ-037 Async reset: pull n_rst low between clock edges mid-stream -> all outputs 0 before the next edge; after release, first accept of a=0x0042 gives max_val=min_val=0x0042.
